// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end for the calculator datapath.
// Optional CALC_ARB_LOCK_EN: a locked winner keeps the grant when it re-requests immediately.
module calc_arbiter #(
  parameter int BITS      = 32,
  parameter int DP_SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      lock,
  input  logic [1:0]      op0,
  input  logic [1:0]      op1,
  input  logic [15:0]     operand0,
  input  logic [15:0]     operand1,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [BITS-1:0] result,
  output logic            busy,
  output logic            dp_start,
  output logic            dp_reset,
  output logic [4:0]      dp_buttons,
  output logic [15:0]     dp_switch,
  input  logic [BITS-1:0] dp_accum
);

  // Button bit indices as defined by calculator_pkg
  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(DP_SETTLE - 1);

  logic [2:0]  state;
  logic        winner;
  logic        last;
  logic [1:0]  op_q;
  logic [3:0]  cnt;
  logic        pick;
  logic        lock_hit;
  logic [1:0]  pick_op;
  logic [15:0] pick_opnd;

`ifdef CALC_ARB_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= (state == S_RESP) ? lock[winner] : 1'b0;
  end

  assign lock_hit = lock_q && req[winner];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_hit    = 1'b0;
`endif

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (lock_hit)         pick = winner;
    else if (&req)        pick = ~last;
    else if (req[1])      pick = 1'b1;
    pick_op   = pick ? op1 : op0;
    pick_opnd = pick ? operand1 : operand0;
  end

  function automatic logic [4:0] op_buttons(input logic [1:0] op);
    logic [4:0] b;
    b = '0;
    case (op)
      OP_ADD:  b[BTN_LEFT]  = 1'b1;
      OP_SUB:  b[BTN_RIGHT] = 1'b1;
      OP_MUL:  b[BTN_UP]    = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      winner     <= 1'b0;
      last       <= 1'b1;
      op_q       <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      result     <= '0;
      busy       <= 1'b0;
      dp_start   <= 1'b0;
      dp_reset   <= 1'b0;
      dp_buttons <= '0;
      dp_switch  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          if (|req) begin
            winner     <= pick;
            if (!lock_hit) last <= pick;
            op_q       <= pick_op;
            gnt        <= pick ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            dp_switch  <= pick_opnd;
            dp_start   <= (pick_op != OP_CLR);
            dp_reset   <= (pick_op == OP_CLR);
            dp_buttons <= op_buttons(pick_op);
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dp_start   <= 1'b0;
          dp_reset   <= 1'b0;
          dp_buttons <= '0;
          if (op_q == OP_CLR) begin
            cnt   <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt   <= SETTLE_LOAD;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            result <= dp_accum;
            done   <= winner ? 2'b10 : 2'b01;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a small behavioural calculator datapath.
module tb_calc_arbiter;

  localparam logic [4:0] B_LEFT = 5'b01000;
  localparam logic [4:0] B_UP   = 5'b00010;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, lock, op0, op1, gnt, done;
  logic [15:0] operand0, operand1, dp_switch;
  logic [31:0] result, dp_accum;
  logic        busy, dp_start, dp_reset;
  logic [4:0]  dp_buttons;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_arbiter #(.BITS(32), .DP_SETTLE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .op0(op0), .op1(op1),
    .operand0(operand0), .operand1(operand1), .gnt(gnt), .done(done),
    .result(result), .busy(busy), .dp_start(dp_start), .dp_reset(dp_reset),
    .dp_buttons(dp_buttons), .dp_switch(dp_switch), .dp_accum(dp_accum)
  );

  // Calculator datapath model: LEFT add, RIGHT sub, UP mul on a start pulse.
  logic [31:0] sw_ext;
  assign sw_ext = {{16{dp_switch[15]}}, dp_switch};
  always_ff @(posedge clk) begin
    if (reset || dp_reset) dp_accum <= '0;
    else if (dp_start) begin
      case (dp_buttons)
        5'b01000: dp_accum <= dp_accum + sw_ext;
        5'b10000: dp_accum <= dp_accum - sw_ext;
        5'b00010: dp_accum <= dp_accum * sw_ext;
        default:  dp_accum <= dp_accum;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic [1:0] mask, input int budget, output int n);
    n = 0;
    while (done !== mask && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_gnt(input int budget, output int n);
    n = 0;
    while (gnt === 2'b00 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; lock = '0; op0 = '0; op1 = '0; operand0 = '0; operand1 = '0;
    tick(); tick();
    checks++;
    if ({gnt, done, busy, dp_start, dp_reset, dp_buttons, dp_switch, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b start=%b clr=%b btn=%b sw=%h res=%h, expected all zero",
               gnt, done, busy, dp_start, dp_reset, dp_buttons, dp_switch, result);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_mul();
    int n;
    req = 2'b01; op0 = 2'd0; operand0 = 16'd5;
    tick();
    checks++;
    if ({gnt, dp_start, dp_buttons, dp_switch, busy} !== {2'b01, 1'b1, B_LEFT, 16'd5, 1'b1}) begin
      errors++;
      $display("FAIL add_issue: got gnt=%b start=%b btn=%b sw=%h busy=%b, expected 01 1 %b 0005 1",
               gnt, dp_start, dp_buttons, dp_switch, busy, B_LEFT);
    end
    tick();
    checks++;
    if ({dp_start, dp_buttons, dp_switch, done} !== {1'b0, 5'b0, 16'd5, 2'b00}) begin
      errors++;
      $display("FAIL add_exec: got start=%b btn=%b sw=%h done=%b, expected 0 00000 0005 00",
               dp_start, dp_buttons, dp_switch, done);
    end
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++; $display("FAIL add_settle_done: got %b expected 00", done);
    end
    tick();
    checks++;
    if ({done, gnt, result} !== {2'b01, 2'b01, 32'd5}) begin
      errors++;
      $display("FAIL add_resp: got done=%b gnt=%b result=%h, expected 01 01 00000005", done, gnt, result);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({done, gnt, busy, result} !== {2'b00, 2'b00, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL add_idle: got done=%b gnt=%b busy=%b result=%h, expected 00 00 0 00000005",
               done, gnt, busy, result);
    end
    req = 2'b01; op0 = 2'd2; operand0 = 16'hFFFD;
    tick();
    checks++;
    if (dp_buttons !== B_UP) begin
      errors++; $display("FAIL mul_buttons: got %b expected %b", dp_buttons, B_UP);
    end
    wait_done(2'b01, 10, n);
    checks++;
    if (n != 3 || result !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL mul_result: got latency %0d result %h, expected 3 FFFFFFF1", n, result);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_tie();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    req = 2'b11; op0 = 2'd0; op1 = 2'd0; operand0 = 16'd1; operand1 = 16'd1;
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++; $display("FAIL tie_first_gnt: got %b expected 01", gnt);
    end
    wait_done(2'b01, 10, n);
    checks++;
    if (done !== 2'b01 || result !== 32'd1) begin
      errors++; $display("FAIL tie_first_result: got done=%b result=%h, expected 01 00000001", done, result);
    end
    req = 2'b10;
    tick(); tick();
    checks++;
    if (gnt !== 2'b10) begin
      errors++; $display("FAIL tie_second_gnt: got %b expected 10", gnt);
    end
    wait_done(2'b10, 10, n);
    checks++;
    if (done !== 2'b10 || result !== 32'd2) begin
      errors++; $display("FAIL tie_second_result: got done=%b result=%h, expected 10 00000002", done, result);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_clear();
    int n;
    req = 2'b10; op1 = 2'd0; operand1 = 16'd5;
    tick();
    wait_done(2'b10, 10, n);
    checks++;
    if (result !== 32'd7) begin
      errors++; $display("FAIL clear_setup: got result %h expected 00000007", result);
    end
    req = 2'b00;
    tick();
    req = 2'b10; op1 = 2'd3;
    tick();
    checks++;
    if ({gnt, dp_reset, dp_start, dp_buttons} !== {2'b10, 1'b1, 1'b0, 5'b0}) begin
      errors++;
      $display("FAIL clear_issue: got gnt=%b clr=%b start=%b btn=%b, expected 10 1 0 00000",
               gnt, dp_reset, dp_start, dp_buttons);
    end
    tick();
    checks++;
    if (dp_reset !== 1'b0 || done !== 2'b00) begin
      errors++; $display("FAIL clear_settle: got clr=%b done=%b, expected 0 00", dp_reset, done);
    end
    tick();
    checks++;
    if (done !== 2'b10 || result !== 32'd0) begin
      errors++; $display("FAIL clear_resp: got done=%b result=%h, expected 10 00000000", done, result);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    req = 2'b11; op0 = 2'd0; op1 = 2'd0; operand0 = 16'd9; operand1 = 16'd4;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt, done, busy, dp_start, dp_reset, dp_buttons, dp_switch, result} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got gnt=%b done=%b busy=%b start=%b clr=%b btn=%b sw=%h res=%h, expected all zero",
               gnt, done, busy, dp_start, dp_reset, dp_buttons, dp_switch, result);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++; $display("FAIL midreset_tie: got %b expected 01", gnt);
    end
    wait_done(2'b01, 10, n);
    checks++;
    if (done !== 2'b01 || result !== 32'd9) begin
      errors++; $display("FAIL midreset_result: got done=%b result=%h, expected 01 00000009", done, result);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++; $display("FAIL done_pulse_width: got %b expected 00", done);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] exp_seq [3];
`ifdef CALC_ARB_LOCK_EN
    exp_seq = '{2'b01, 2'b01, 2'b01};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01};
`endif
    reset = 1'b1; tick(); reset = 1'b0;
    lock = 2'b01; req = 2'b11; op0 = 2'd0; op1 = 2'd0; operand0 = 16'd1; operand1 = 16'd1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(10, n);
      checks++;
      if (gnt !== exp_seq[k] || n != 1) begin
        errors++;
        $display("FAIL rr_grant_%0d: got gnt=%b after %0d cycles, expected %b after 1", k, gnt, n, exp_seq[k]);
      end
      wait_done(exp_seq[k], 10, n);
      checks++;
      if (done !== exp_seq[k] || n != 3) begin
        errors++;
        $display("FAIL rr_done_%0d: got done=%b after %0d cycles, expected %b after 3", k, done, n, exp_seq[k]);
      end
      tick();
    end
    req = 2'b00; lock = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_mul();
    test_tie();
    test_clear();
    test_reset_mid();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32, accumulator/result width; must match the calculator datapath's BITS.
REQ-002 SHALL have parameter DP_SETTLE, default 1, cycles waited after execute before sampling accumulator; legal range 1..15.
REQ-003 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have req  input  2  per-requester operation request, level, held until done.
REQ-006 SHALL have lock  input  2  per-requester grant-retain hint (see Configuration).
REQ-007 SHALL have op0, op1  input  2 each  op code: 0 add, 1 sub, 2 mul, 3 clear.
REQ-008 SHALL have operand0, operand1  input  16 each  signed operand.
REQ-009 SHALL have gnt  output  2  one-hot-or-zero grant, high from ISSUE through RESP.
REQ-010 SHALL have done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have result  output  BITS  accumulator snapshot, valid when done is high, held until next done.
REQ-012 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have dp_start, dp_reset  output  1 each  datapath start pulse and clear pulse.
REQ-014 SHALL have dp_buttons  output  5  one-hot op to datapath using calculator_pkg bit indices.
REQ-015 SHALL have dp_switch  output  16  operand to datapath.
REQ-016 SHALL have dp_accum  input  BITS  datapath accumulator.

Function
REQ-017 SHALL implement states IDLE, ISSUE, EXEC, SETTLE, RESP, all registered outputs.
REQ-018 In IDLE with any req high, SHALL select a winner, latch its op/operand, assert gnt and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: single request wins; on simultaneous requests, the requester not served last wins.
REQ-020 ISSUE (1 cycle): add/sub/mul SHALL drive dp_start=1, dp_buttons = LEFT/RIGHT/UP one-hot, dp_switch = operand; next state EXEC.
REQ-021 ISSUE for clear SHALL drive dp_reset=1, dp_start=0, dp_buttons=0 and go directly to SETTLE.
REQ-022 EXEC (1 cycle): dp_start=0, dp_buttons=0, dp_switch held at operand; next state SETTLE.
REQ-023 SETTLE SHALL last exactly DP_SETTLE cycles (down-counter), dp_switch held; then RESP.
REQ-024 RESP (1 cycle): result <= dp_accum, done[winner]=1, gnt cleared at end of cycle, next state IDLE.
REQ-025 Latency: req seen at edge T gives gnt at T+1, done at T+3+DP_SETTLE (arith) or T+2+DP_SETTLE (clear).
REQ-026 Requester dropping req before grant SHALL be ignored; dropping after grant SHALL NOT abort the operation, done still pulses.
REQ-027 Back-to-back: at most one idle cycle between done and next gnt; IDLE always consumes one cycle.
REQ-028 Arithmetic width and overflow SHALL be the datapath's; arbiter passes dp_accum unmodified.

Reset
REQ-029 On reset: state IDLE, gnt=0, done=0, busy=0, dp_start=0, dp_reset=0, dp_buttons=0, dp_switch=0, result=0, SETTLE counter=0, round-robin pointer set so requester 0 wins first tie.
REQ-030 Reset mid-operation SHALL abort without a done pulse; reset has priority over every state transition.

Configuration
REQ-031 Macro CALC_ARB_LOCK_EN defined: if lock[winner] is high in RESP and req[winner] is high in the following IDLE cycle, the same requester SHALL win regardless of round-robin; pointer not updated.
REQ-032 Macro CALC_ARB_LOCK_EN undefined: lock SHALL be ignored; pure round-robin.

Verification
REQ-033 Reset, req=01 op0=0 operand0=5 -> gnt=01 at T+1, dp_start pulse, done=01 at T+4, result=5.
REQ-034 Then req=01 op0=2 operand0=-3 -> result=0xFFFFFFF1 (-15).
REQ-035 req=11 simultaneously from reset, both op=0 operand 1 -> requester 0 done first with result 1, requester 1 next with result 2.
REQ-036 op1=3 with accumulator 7 -> dp_reset pulse one cycle, done=10 at T+3, result=0.
REQ-037 reset asserted in SETTLE -> no done pulse, all outputs 0 next cycle, subsequent tie goes to requester 0.
REQ-038 With CALC_ARB_LOCK_EN, lock=01, req=11 continuously -> requester 0 served 3 times consecutively; without macro -> grants alternate 0,1,0.
